// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and {cpol,cpha} mode constants for the SPI master
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: DIV-cycle half-period timer giving an edge strobe and a leading/trailing flag
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic run,
    output logic tick,
    output logic lead
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt;
    logic          ph;
    assign tick = en && cnt == CW'(DIV - 1);
    assign lead = !ph;
    // phase restarts outside XFER so the first XFER strobe is always a leading edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            ph  <= 1'b0;
        end else begin
            cnt <= (!en || tick) ? '0 : cnt + 1'b1;
            ph  <= !run ? 1'b0 : ph ^ tick;
        end
endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: full-duplex MSB-first SPI master, all CPOL/CPHA modes, one-hot active-low chip selects
// Define SPI_LOOPBACK_EN to sample the internal mosi instead of the miso pin.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIV    = 4,
    parameter int NUM_CS = 2,
    parameter int CS_W   = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CS_W-1:0]             cs_sel,
    input  logic                        cpol,
    input  logic                        cpha,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        miso,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        busy,
    output logic                        done,
    output logic                        sclk,
    output logic                        mosi,
    output logic [NUM_CS-1:0]           cs_n,
    output logic [$clog2(DATA_W+1)-1:0] bit_cnt
);
    localparam int BW = $clog2(DATA_W + 1);
    state_t            state, nxt;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic [CS_W-1:0]   cs_q;
    logic              cpol_q, cpha_q, tick, lead, go, last, smp, drv, sbit;

    spi_clk_gen #(.DIV(DIV)) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .run  (state == XFER),
        .tick (tick),
        .lead (lead)
    );

    assign go   = state == IDLE && start;
    // the final edge is a trailing one; bit_cnt tells us whether it still has a sample to take
    assign last = state == XFER && tick && !lead && bit_cnt == (cpha_q ? BW'(1) : BW'(0));
    assign smp  = state == XFER && tick && (lead ^ cpha_q);
    assign drv  = state == XFER && tick && (cpha_q ? lead : !lead && !last);
`ifdef SPI_LOOPBACK_EN
    assign sbit = mosi;
`else
    assign sbit = miso;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    always_comb
        nxt = state == IDLE  ? (start ? SETUP : IDLE) :
              state == SETUP ? (tick ? XFER : SETUP) :
              state == XFER  ? (last ? HOLD : XFER) :
                               (tick ? IDLE : HOLD);

    // out-of-range cs_sel shifts the one-hot mask out entirely, leaving every line high
    always_comb begin
        busy = state != IDLE;
        cs_n = busy ? ~(NUM_CS'(1) << cs_q) : '1;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            cs_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            done    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            done <= state == HOLD && tick;
            if (go) begin
                cs_q    <= cs_sel;
                cpol_q  <= cpol;
                cpha_q  <= cpha;
                sclk    <= cpol;
                bit_cnt <= BW'(DATA_W);
                rx_sh   <= '0;
                tx_sh   <= cpha ? tx_data : tx_data << 1;
                mosi    <= cpha ? mosi : tx_data[DATA_W-1];
            end
            if (state == XFER && tick) sclk <= ~sclk;
            if (drv) begin
                mosi  <= tx_sh[DATA_W-1];
                tx_sh <= tx_sh << 1;
            end
            if (smp) begin
                rx_sh   <= {rx_sh[DATA_W-2:0], sbit};
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (state == HOLD && tick) rx_data <= rx_sh;
        end
endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master that shifts a DATA_W-bit word out on mosi while capturing DATA_W bits from miso, with programmable SCLK divider, all four CPOL/CPHA modes and NUM_CS one-hot active-low chip selects. It sits between a register/control front end, which issues start with a word, and the external SPI pins. Full-duplex, MSB first, one word per transaction.

## Interface
- DATA_W, 16, bits per transfer (≥2)
- DIV, 4, clk cycles per SCLK half-period (≥1)
- NUM_CS, 2, number of chip-select lines (≥1)
- CS_W, $clog2(NUM_CS) min 1, derived select width
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request transfer; sampled only in IDLE
- cs_sel  in  CS_W  target slave index, latched at start
- cpol  in  1  SCLK idle level, latched at start
- cpha  in  1  clock phase, latched at start
- tx_data  in  DATA_W  word to send, latched at start
- miso  in  1  serial data from slave
- rx_data  out  DATA_W  last received word
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- sclk  out  1  SPI clock
- mosi  out  1  serial data to slave
- cs_n  out  NUM_CS  active-low chip selects
- bit_cnt  out  $clog2(DATA_W+1)  bits remaining to sample

## Operation
- States: IDLE, SETUP, XFER, HOLD. busy = (state != IDLE).
- IDLE: start=1 latches tx_data/cs_sel/cpol/cpha, loads bit_cnt=DATA_W, moves to SETUP.
- SETUP (DIV cycles): cs_n[cs_sel] low, sclk=cpol; cpha=0 drives mosi=tx MSB on entry.
- XFER: sclk toggles every DIV cycles, 2*DATA_W edges numbered 0..2*DATA_W-1; even edges are leading, odd edges trailing.
- cpha=0: sample miso on leading edges; shift mosi to next bit on trailing edges except the last.
- cpha=1: drive mosi on leading edges (edge 0 drives MSB); sample miso on trailing edges.
- Each sample shifts miso into internal rx shift register LSB and decrements bit_cnt; bit_cnt reaches 0 on the final sample.
- After last edge sclk rests at cpol; HOLD for DIV cycles, cs_n stays asserted.
- HOLD→IDLE: cs_n all high, rx_data ← shift register, done=1 for one cycle.
- rx_data changes only in the done cycle.
- start while busy: ignored. start in the done cycle (IDLE): accepted, back-to-back allowed.
- cs_sel ≥ NUM_CS: transfer runs normally, all cs_n stay high.

## Timing
- Reset values: cs_n all 1, sclk 0, mosi 0, rx_data 0, busy 0, done 0, bit_cnt 0, state IDLE.
- Start sampled at edge t0 → busy from t0; done and busy=0 at t0 + (2*DATA_W+2)*DIV.
- Reset mid-transfer: all outputs to reset values immediately (async), no done, shift register cleared; next start behaves as from power-up.
- All outputs registered; no combinational path from inputs to outputs.
- DIV=1: SCLK = clk/2; behaviour otherwise identical.

## Configuration
- SPI_LOOPBACK_EN defined: sampled data taken from internal mosi instead of miso; miso port present but ignored; rx_data equals tx_data in every mode.
- Undefined: miso pin sampled as above.

## Structure
- Package spi_pkg: state enum (IDLE, SETUP, XFER, HOLD), mode constants MODE0..MODE3 as {cpol,cpha}.
- Sub-module spi_clk_gen: DIV counter producing one-cycle edge strobe plus leading/trailing flag; master FSM consumes the strobe.

## Test plan
- Reset: assert rst mid-idle → cs_n=2'b11, sclk=0, mosi=0, rx_data=0, busy=0, done=0.
- Mode 0, DATA_W=16, DIV=2, tx 0xA5C3, slave model returns 0x3C5A → slave receives 0xA5C3, rx_data=0x3C5A, done at t0+68.
- Modes 1–3 with tx 0x8001, slave returns 0x7FFE → correct idle sclk level, sample/drive edges per mode, rx_data=0x7FFE.
- start pulsed at t0+10 while busy → ignored; start in done cycle with tx 0x1234 → second transfer begins immediately, done at +68.
- rst asserted after 5 samples → cs_n high, sclk=cpol reset value 0, no done; next transfer of 0xFFFF completes correctly.
- NUM_CS=2: cs_sel=1 → only cs_n[1] low; cs_sel=0 → only cs_n[0] low. Loopback build: tx 0xBEEF → rx_data=0xBEEF in all modes.
